instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the opcode control decoder: accepts one decoded control-signal bundle plus register/immediate
//  fields per handshake, re-encodes it into a 16-bit instruction word, and writes that word sequentially
//  into instruction memory through a single write port. Used as the program loader/assembler back end
//  ahead of the datapath. Flags illegal bundles.
// PARAMETERS
//  INSTR_W   16  instruction word width (opcode [15:12], rs [11:9], rt [8:6], rd [5:3] / imm6 [5:0] / imm12 [11:0])
//  ADDR_W    8   instruction-memory word-address width
// PORTS
//  clk          in   1        single clock; all state on rising edge
//  reset        in   1        synchronous, active-high
//  start        in   1        1-cycle pulse: load write pointer from base_addr, clear sticky flags, enter RUN
//  base_addr    in   ADDR_W   first address to write
//  last_addr    in   ADDR_W   final writable address (inclusive), sampled with start
//  in_valid     in   1        bundle valid
//  in_ready     out  1        encoder can accept a bundle this cycle
//  aluop        in   2        00 data-proc, 01 branch, 10 load/store
//  jump,beq,bne,mem_read,mem_write,alu_src,reg_dst,mem_to_reg,reg_write  in 1 each   decoded controls
//  alu_fn       in   3        data-proc select: opcode = 4'b0010 + alu_fn; alu_fn > 3'd7-... see BEHAVIOUR
//  rs,rt,rd     in   3 each   register fields
//  imm          in   12       immediate; low 6 bits used for I-format, all 12 for J-format
//  imem_we      out  1        instruction-memory write strobe
//  imem_addr    out  ADDR_W   write address
//  imem_wdata   out  INSTR_W  encoded instruction
//  full         out  1        last_addr written; no further accepts until start
//  err          out  1        1-cycle pulse: accepted bundle was illegal, nothing written
//  err_sticky   out  1        set by err, cleared by start/reset
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, full=0, err=0, err_sticky=0.
//  FSM: IDLE -start-> RUN; RUN -accept(legal)-> WRITE; RUN -accept(illegal)-> RUN (err=1 next cycle);
//       WRITE -> RUN if ptr!=last_addr else FULL; FULL -start-> RUN. start is honoured in every state
//       (priority over accept); a pending WRITE is dropped when start coincides with it.
//  in_ready=1 only in RUN; accept = in_valid & in_ready. Throughput 1 bundle / 2 cycles.
//  Latency: imem_we=1 exactly 1 cycle after accept, addr=ptr, wdata registered; ptr increments after write.
//  Classification (priority order, first match wins):
//   jump                                           -> 1101, J: {op, imm[11:0]}
//   beq & aluop==01                                -> 1011, I: {op, rs, rt, imm[5:0]}
//   bne & aluop==01                                -> 1100, I
//   mem_read & mem_to_reg & reg_write & alu_src & aluop==10 -> 0000 (LW), I
//   mem_write & alu_src & aluop==10                -> 0001 (SW), I
//   reg_dst & reg_write & aluop==00 & alu_fn<=3'd7 -> 0010+alu_fn (0010..1001), R: {op, rs, rt, rd, 3'b000}
//   anything else, or beq&bne both 1              -> illegal.
//  Opcodes 1010, 1110, 1111 are never produced.
//  FULL: write at ptr==last_addr completes, then full=1, in_ready=0. base_addr>last_addr: first write
//   still occurs at base_addr, then FULL (no wrap). Pointer never wraps past 2^ADDR_W-1.
//  reset mid-write: imem_we deasserts on the next edge, write is lost.
// CONFIGURATION
//  ENC_STRICT_CHECK_EN defined: bundle must exactly match the full decoder row for its class (every
//   unlisted control = 0, e.g. LW needs mem_write=0, beq=0, bne=0, jump=0, reg_dst=0); mismatch -> illegal.
//  Undefined: only the key bits above are checked; extra asserted controls ignored.
// STRUCTURE
//  Shared package: opcode localparams (OP_LW..OP_J), aluop codes, field bit positions, FSM state encoding.
//  One sub-module: instr_encode_comb (pure combinational bundle -> {word, legal}); FSM/pointer here.
// TESTING
//  reset, start base=0x10 last=0x13; LW rs=1 rt=2 imm=5 -> imem_we@0x10, wdata=16'h0285
//  R-format alu_fn=3 rs=1 rt=2 rd=3 (aluop 00, reg_dst, reg_write) -> wdata=16'h5298 next slot
//  jump imm=12'hABC -> 16'hDABC; beq+bne both 1 -> err pulse, err_sticky=1, no imem_we, ptr unchanged
//  4 legal bundles base=0x10 last=0x13 -> writes 0x10..0x13, then full=1, in_ready=0; start clears full
//  ENC_STRICT_CHECK_EN: LW bundle with mem_write=1 -> err; without macro -> written as 16'h0xxx LW
//  start asserted in the WRITE cycle -> no write, imem_addr next = new base_addr, err_sticky=0

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcodes, aluop codes, field positions, control patterns and FSM states
package instr_encoder_pkg;
    localparam int WORD_W = 16;
    localparam int OP_LSB = 12;
    localparam int RS_LSB = 9;
    localparam int RT_LSB = 6;
    localparam int RD_LSB = 3;
    localparam logic [3:0] OP_LW  = 4'h0;
    localparam logic [3:0] OP_SW  = 4'h1;
    localparam logic [3:0] OP_R   = 4'h2;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_J   = 4'hD;
    localparam logic [1:0] ALU_DP = 2'b00;
    localparam logic [1:0] ALU_BR = 2'b01;
    localparam logic [1:0] ALU_LS = 2'b10;
    // control vector order: {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write}
    localparam logic [8:0] CTL_J   = 9'b100000000;
    localparam logic [8:0] CTL_BEQ = 9'b010000000;
    localparam logic [8:0] CTL_BNE = 9'b001000000;
    localparam logic [8:0] CTL_LW  = 9'b000101011;
    localparam logic [8:0] CTL_SW  = 9'b000011000;
    localparam logic [8:0] CTL_R   = 9'b000000101;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_FULL} state_t;
endpackage

// File: rtl/instr_encode_comb.sv
// instr_encode_comb: bundle -> {word, legal}; ENC_STRICT_CHECK_EN demands exact decoder rows
module instr_encode_comb
    import instr_encoder_pkg::*;
(
    input  logic [1:0]        aluop,
    input  logic [8:0]        ctl,
    input  logic [2:0]        alu_fn,
    input  logic [2:0]        rs,
    input  logic [2:0]        rt,
    input  logic [2:0]        rd,
    input  logic [11:0]       imm,
    output logic [WORD_W-1:0] word,
    output logic              legal
);
`ifdef ENC_STRICT_CHECK_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    // lenient mode only looks at the bits that must be set; strict compares every control
    function automatic logic hit(input logic [8:0] c, input logic [8:0] pat);
        return ((c ^ pat) & (STRICT ? 9'h1FF : pat)) == 9'h000;
    endfunction
    always_comb begin
        word = '0;
        legal = 1'b1;
        if (ctl[7] & ctl[6])
            legal = 1'b0;
        else if (hit(ctl, CTL_J) && (!STRICT || aluop == ALU_DP))
            word = {OP_J, imm};
        else if (hit(ctl, CTL_BEQ) && aluop == ALU_BR)
            word = {OP_BEQ, rs, rt, imm[5:0]};
        else if (hit(ctl, CTL_BNE) && aluop == ALU_BR)
            word = {OP_BNE, rs, rt, imm[5:0]};
        else if (hit(ctl, CTL_LW) && aluop == ALU_LS)
            word = {OP_LW, rs, rt, imm[5:0]};
        else if (hit(ctl, CTL_SW) && aluop == ALU_LS)
            word = {OP_SW, rs, rt, imm[5:0]};
        else if (hit(ctl, CTL_R) && aluop == ALU_DP)
            word = {OP_R + {1'b0, alu_fn}, rs, rt, rd, 3'b000};
        else
            legal = 1'b0;
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: re-encodes control bundles and writes them sequentially to imem (ENC_STRICT_CHECK_EN selects strict checking)
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         aluop,
    input  logic               jump,
    input  logic               beq,
    input  logic               bne,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               alu_src,
    input  logic               reg_dst,
    input  logic               mem_to_reg,
    input  logic               reg_write,
    input  logic [2:0]         alu_fn,
    input  logic [2:0]         rs,
    input  logic [2:0]         rt,
    input  logic [2:0]         rd,
    input  logic [11:0]        imm,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               full,
    output logic               err,
    output logic               err_sticky
);
    state_t state;
    logic [ADDR_W-1:0] ptr, last;
    logic [WORD_W-1:0] word;
    logic legal;
    instr_encode_comb u_comb (
        .aluop  (aluop),
        .ctl    ({jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write}),
        .alu_fn (alu_fn),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .imm    (imm),
        .word   (word),
        .legal  (legal)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            in_ready <= 1'b0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wdata <= '0;
            full <= 1'b0;
            err <= 1'b0;
            err_sticky <= 1'b0;
            ptr <= '0;
            last <= '0;
        end else begin
            imem_we <= 1'b0;
            err <= 1'b0;
            if (start) begin
                state <= S_RUN;
                in_ready <= 1'b1;
                ptr <= base_addr;
                last <= last_addr;
                imem_addr <= base_addr;
                full <= 1'b0;
                err_sticky <= 1'b0;
            end else begin
                case (state)
                    S_RUN: if (in_valid) begin
                        if (legal) begin
                            state <= S_WRITE;
                            in_ready <= 1'b0;
                            imem_we <= 1'b1;
                            imem_addr <= ptr;
                            imem_wdata <= word;
                        end else begin
                            err <= 1'b1;
                            err_sticky <= 1'b1;
                        end
                    end
                    // >= also catches base_addr > last_addr and stops the pointer from wrapping
                    S_WRITE: if (ptr >= last) begin
                        state <= S_FULL;
                        full <= 1'b1;
                    end else begin
                        state <= S_RUN;
                        in_ready <= 1'b1;
                        ptr <= ptr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven and directed checks of instr_encoder
module tb_instr_encoder;
    logic clk = 1'b0;
    logic reset, start, in_valid, in_ready;
    logic [7:0] base_addr, last_addr, imem_addr;
    logic [1:0] aluop;
    logic [8:0] ctl;
    logic jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
    logic [2:0] alu_fn, rs, rt, rd;
    logic [11:0] imm;
    logic imem_we, full, err, err_sticky;
    logic [15:0] imem_wdata;
    assign {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write} = ctl;
    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .last_addr(last_addr),
        .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop), .jump(jump), .beq(beq), .bne(bne),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_fn(alu_fn), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .full(full),
        .err(err), .err_sticky(err_sticky)
    );

    typedef struct {
        logic [1:0] aluop;
        logic [8:0] ctl;
        logic [2:0] fn, rs, rt, rd;
        logic [11:0] imm;
        logic legal;
        logic [15:0] word;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[15];
    logic [7:0] p;

    function automatic vec_t mk(input logic [1:0] a, input logic [8:0] c, input logic [2:0] f,
                                input logic [2:0] s, input logic [2:0] t, input logic [2:0] d,
                                input logic [11:0] i, input logic l, input logic [15:0] w);
        vec_t v;
        v.aluop = a; v.ctl = c; v.fn = f; v.rs = s; v.rt = t; v.rd = d; v.imm = i; v.legal = l; v.word = w;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        aluop = v.aluop; ctl = v.ctl; alu_fn = v.fn; rs = v.rs; rt = v.rt; rd = v.rd; imm = v.imm;
    endtask

    task automatic wait_ready(input string nm);
        for (int i = 0; i < 16 && in_ready !== 1'b1; i++) tick();
        chk(nm, in_ready, 1);
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] l);
        start = 1'b1; base_addr = b; last_addr = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input vec_t v);
        drive(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(2'b10, 9'b000101011, 3'd0, 3'd1, 3'd2, 3'd0, 12'h005, 1'b1, 16'h0285);
        vecs[1]  = mk(2'b00, 9'b000000101, 3'd3, 3'd1, 3'd2, 3'd3, 12'h000, 1'b1, 16'h5298);
        vecs[2]  = mk(2'b00, 9'b100000000, 3'd0, 3'd0, 3'd0, 3'd0, 12'hABC, 1'b1, 16'hDABC);
        vecs[3]  = mk(2'b01, 9'b011000000, 3'd0, 3'd1, 3'd2, 3'd0, 12'h001, 1'b0, 16'h0000);
        vecs[4]  = mk(2'b01, 9'b010000000, 3'd0, 3'd7, 3'd0, 3'd0, 12'hFFF, 1'b1, 16'hBE3F);
        vecs[5]  = mk(2'b01, 9'b001000000, 3'd0, 3'd2, 3'd5, 3'd0, 12'h02A, 1'b1, 16'hC56A);
        vecs[6]  = mk(2'b10, 9'b000011000, 3'd0, 3'd3, 3'd4, 3'd0, 12'h010, 1'b1, 16'h1710);
        vecs[7]  = mk(2'b00, 9'b000000101, 3'd7, 3'd0, 3'd0, 3'd7, 12'h000, 1'b1, 16'h9038);
        vecs[8]  = mk(2'b00, 9'b000000101, 3'd0, 3'd7, 3'd7, 3'd7, 12'h000, 1'b1, 16'h2FF8);
        vecs[9]  = mk(2'b00, 9'b000000000, 3'd0, 3'd0, 3'd0, 3'd0, 12'h000, 1'b0, 16'h0000);
        vecs[10] = mk(2'b00, 9'b010000000, 3'd0, 3'd1, 3'd1, 3'd0, 12'h001, 1'b0, 16'h0000);
        vecs[11] = mk(2'b10, 9'b000100011, 3'd0, 3'd1, 3'd2, 3'd0, 12'h005, 1'b0, 16'h0000);
        vecs[12] = mk(2'b11, 9'b000000101, 3'd1, 3'd1, 3'd1, 3'd1, 12'h000, 1'b0, 16'h0000);
`ifdef ENC_STRICT_CHECK_EN
        vecs[13] = mk(2'b10, 9'b000111011, 3'd0, 3'd1, 3'd2, 3'd0, 12'h005, 1'b0, 16'h0000);
        vecs[14] = mk(2'b00, 9'b100000001, 3'd0, 3'd0, 3'd0, 3'd0, 12'h123, 1'b0, 16'h0000);
`else
        vecs[13] = mk(2'b10, 9'b000111011, 3'd0, 3'd1, 3'd2, 3'd0, 12'h005, 1'b1, 16'h0285);
        vecs[14] = mk(2'b00, 9'b100000001, 3'd0, 3'd0, 3'd0, 3'd0, 12'h123, 1'b1, 16'hD123);
`endif
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = '0; last_addr = '0;
        drive(vecs[0]);
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_err_sticky", err_sticky, 0);
        reset = 1'b0;
        send(vecs[0]);
        chk("idle_no_write", imem_we, 0);
        chk("idle_not_ready", in_ready, 0);

        // fill 0x10..0x13 with an illegal bundle in the middle
        do_start(8'h10, 8'h13);
        chk("start_ready", in_ready, 1);
        send(vecs[0]);
        chk("lw_we", imem_we, 1);
        chk("lw_addr", imem_addr, 8'h10);
        chk("lw_wdata", imem_wdata, 16'h0285);
        chk("write_not_ready", in_ready, 0);
        tick();
        chk("write_strobe_1cyc", imem_we, 0);
        wait_ready("ready_r");
        send(vecs[1]);
        chk("r_addr", imem_addr, 8'h11);
        chk("r_wdata", imem_wdata, 16'h5298);
        tick();
        wait_ready("ready_j");
        send(vecs[2]);
        chk("j_addr", imem_addr, 8'h12);
        chk("j_wdata", imem_wdata, 16'hDABC);
        tick();
        wait_ready("ready_bad");
        send(vecs[3]);
        chk("bad_err", err, 1);
        chk("bad_no_we", imem_we, 0);
        chk("bad_sticky", err_sticky, 1);
        chk("bad_still_ready", in_ready, 1);
        tick();
        chk("err_pulse_1cyc", err, 0);
        chk("sticky_held", err_sticky, 1);
        send(vecs[0]);
        chk("last_addr_ptr_kept", imem_addr, 8'h13);
        chk("last_we", imem_we, 1);
        tick();
        chk("full_set", full, 1);
        chk("full_not_ready", in_ready, 0);
        send(vecs[0]);
        chk("full_no_write", imem_we, 0);
        tick();
        chk("full_still_no_write", imem_we, 0);
        do_start(8'h40, 8'hFF);
        chk("start_clr_full", full, 0);
        chk("start_clr_sticky", err_sticky, 0);

        p = 8'h40;
        for (int i = 0; i < 15; i++) begin
            wait_ready($sformatf("v%0d_ready", i));
            send(vecs[i]);
            chk($sformatf("v%0d_we", i), imem_we, {31'd0, vecs[i].legal});
            chk($sformatf("v%0d_err", i), err, {31'd0, ~vecs[i].legal});
            if (vecs[i].legal) begin
                chk($sformatf("v%0d_addr", i), imem_addr, p);
                chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].word);
                p = p + 8'd1;
                tick();
            end
        end
        chk("sticky_after_table", err_sticky, 1);

        // start beats a coincident accept
        wait_ready("coinc_ready");
        drive(vecs[0]);
        in_valid = 1'b1; start = 1'b1; base_addr = 8'h80; last_addr = 8'h90;
        tick();
        in_valid = 1'b0; start = 1'b0;
        chk("coinc_no_write", imem_we, 0);
        chk("coinc_addr_base", imem_addr, 8'h80);
        chk("coinc_sticky_clr", err_sticky, 0);
        send(vecs[0]);
        chk("coinc_first_addr", imem_addr, 8'h80);
        start = 1'b1; base_addr = 8'h50; last_addr = 8'h60;
        tick();
        start = 1'b0;
        chk("wstart_no_we", imem_we, 0);
        chk("wstart_addr", imem_addr, 8'h50);
        send(vecs[2]);
        chk("wstart_next_addr", imem_addr, 8'h50);
        tick();

        // base above last: one write then full
        do_start(8'h30, 8'h20);
        send(vecs[0]);
        chk("inv_range_addr", imem_addr, 8'h30);
        chk("inv_range_we", imem_we, 1);
        tick();
        chk("inv_range_full", full, 1);
        do_start(8'hFF, 8'hFF);
        send(vecs[1]);
        chk("top_addr", imem_addr, 8'hFF);
        tick();
        chk("top_full", full, 1);
        chk("top_not_ready", in_ready, 0);

        // reset during the write cycle
        do_start(8'h00, 8'h05);
        send(vecs[0]);
        chk("pre_rst_we", imem_we, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_we", imem_we, 0);
        chk("midrst_ready", in_ready, 0);
        tick();
        chk("midrst_idle", in_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
